dct_mul_sched: RTL and testbench

Round-robin issue scheduler for the fixed-latency multiplier delay pipeline in the DCT datapath. It arbitrates among up to N_REQ requesters (DCT row/column engines) for the single shared pipeline input. It drives the pipeline's enable and input data, and tracks each issued operand's owner through the pipeline latency. Each result leaves the pipeline tagged with its requester ID and a valid strobe.

---
 rtl/dct_mul_sched.sv | 109 ++++++++++
 tb/tb_dct_mul_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_mul_sched.sv
// dct_mul_sched: round-robin issue scheduler for the shared fixed-latency
// multiplier pipeline in the DCT datapath.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req[N_REQ]          per-requester request level (operand valid while high)
//   req_data            packed operands, requester i at [i*DATA_W +: DATA_W]
//   hold                blocks new grants; in-flight work still drains
//   gnt[N_REQ]          one-hot combinational grant (operand consumed on edge)
//   pipe_enable         pipeline enable, OR of gnt
//   pipe_in_data        granted operand, 0 when nothing is granted
//   pipe_out_data       pipeline output, LATENCY edges after issue
//   rsp_valid/id/data   tagged result; id and data are 0 when not valid
//   inflight            issued operations not yet returned
//   idle                nothing in flight and no grant this cycle
module dct_mul_sched #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 7,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_W-1:0]       req_data,
  input  logic                          hold,
  output logic [N_REQ-1:0]              gnt,
  output logic                          pipe_enable,
  output logic [DATA_W-1:0]             pipe_in_data,
  input  logic [DATA_W-1:0]             pipe_out_data,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [$clog2(LATENCY+1)-1:0]  inflight,
  output logic                          idle
);
  localparam int CNT_W = $clog2(LATENCY+1);

  logic [ID_W-1:0]                ptr;
  logic                           found;
  logic [ID_W-1:0]                gnt_id;
  logic [LATENCY-1:0]             vld_pipe;
  logic [LATENCY-1:0][ID_W-1:0]   id_pipe;

  // Search starts at ptr and wraps; first requester found wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    found  = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    // Suppress after the search so hold/rst act in the same cycle.
    if (hold || rst) found = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (found) gnt[gnt_id] = 1'b1;
  end

  assign pipe_enable  = found;
  assign pipe_in_data = found ? req_data[gnt_id*DATA_W +: DATA_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Shadow of the pipeline: owner tags travel alongside the operands. IDs are
  // zeroed on empty slots so rsp_id comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], pipe_enable};
      id_pipe  <= {id_pipe[LATENCY-2:0], (pipe_enable ? gnt_id : ID_W'(0))};
    end
  end

  assign rsp_valid = vld_pipe[LATENCY-1];
  assign rsp_id    = id_pipe[LATENCY-1];
  // Mask whatever the unreset pipeline emits in empty slots.
  assign rsp_data  = rsp_valid ? pipe_out_data : '0;

  // Issue and retire in the same cycle cancel out. The shadow holds at most
  // LATENCY entries, so the guards never bind in normal use.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (pipe_enable && !rsp_valid && inflight != CNT_W'(LATENCY)) begin
      inflight <= inflight + 1'b1;
    end else if (!pipe_enable && rsp_valid && inflight != '0) begin
      inflight <= inflight - 1'b1;
    end
  end

  assign idle = (inflight == '0) && !pipe_enable;

endmodule

// File: tb/tb_dct_mul_sched.sv
module tb_dct_mul_sched;
  localparam int N  = 4;
  localparam int L  = 7;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int CW = 3;
  localparam int VW = N + 1 + DW + 1 + IW + DW + CW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic              hold;
  logic [N-1:0]      gnt;
  logic              pipe_enable;
  logic [DW-1:0]     pipe_in_data;
  logic [DW-1:0]     pipe_out_data;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;
  logic [CW-1:0]     inflight;
  logic              idle;

  always #5 clk = ~clk;

  dct_mul_sched #(.N_REQ(N), .LATENCY(L), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .hold(hold),
    .gnt(gnt), .pipe_enable(pipe_enable), .pipe_in_data(pipe_in_data),
    .pipe_out_data(pipe_out_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .inflight(inflight), .idle(idle)
  );

  // Stand-in for the multiplier: a plain, never-reset delay line.
  logic [DW-1:0] pq [L];
  always @(posedge clk) begin
    pq[0] <= pipe_in_data;
    for (int i = 1; i < L; i++) pq[i] <= pq[i-1];
  end
  assign pipe_out_data = pq[L-1];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int m_ptr    = 0;

  typedef struct {int c; int id; logic [DW-1:0] d;} iss_t;
  iss_t q[$];

  logic [VW-1:0] obs, ex_v;
  logic [N-1:0]  o_gnt;
  logic          o_pe, o_rv, o_idle;
  logic [IW-1:0] o_rid;
  logic [DW-1:0] o_rd, o_pin;
  logic [CW-1:0] o_inf;

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  // Drives one cycle, samples DUT and reference expectation before the edge,
  // then advances the reference model across the edge.
  task automatic step(input logic [N-1:0] r, input logic h, input logic rs,
                      input logic [N*DW-1:0] d);
    int g, cnt;
    logic [N-1:0]  e_gnt;
    logic [DW-1:0] e_pin, e_rd;
    logic          e_rv, e_idle;
    logic [IW-1:0] e_rid;
    req = r; hold = h; rst = rs; req_data = d;
    #1;
    g = -1;
    if (!h && !rs)
      for (int k = 0; k < N; k++)
        if (g < 0 && r[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    while (q.size() > 0 && q[0].c + L < cyc) void'(q.pop_front());
    e_rv = 1'b0; e_rid = '0; e_rd = '0; cnt = 0;
    foreach (q[j]) begin
      if (q[j].c == cyc - L) begin e_rv = 1'b1; e_rid = IW'(q[j].id); e_rd = q[j].d; end
      cnt++;
    end
    e_gnt = '0; e_pin = '0;
    if (g >= 0) begin e_gnt[g] = 1'b1; e_pin = d[g*DW +: DW]; end
    e_idle = (cnt == 0) && (g < 0);
    ex_v = {e_gnt, (g >= 0), e_pin, e_rv, e_rid, e_rd, CW'(cnt), e_idle};
    o_gnt = gnt; o_pe = pipe_enable; o_pin = pipe_in_data; o_rv = rsp_valid;
    o_rid = rsp_id; o_rd = rsp_data; o_inf = inflight; o_idle = idle;
    obs = {o_gnt, o_pe, o_pin, o_rv, o_rid, o_rd, o_inf, o_idle};
    @(posedge clk);
    if (rs) begin
      q.delete(); m_ptr = 0;
    end else if (g >= 0) begin
      q.push_back('{cyc, g, d[g*DW +: DW]});
      m_ptr = (g + 1) % N;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(4'b1111, 1'b0, 1'b1, rnd_data());
    checks++;
    if (o_gnt !== 4'b0000 || o_pe !== 1'b0) begin
      failures++; $display("FAIL reset_gnt: gnt=%b pe=%b, want 0000/0", o_gnt, o_pe);
    end
    step(4'b0000, 1'b0, 1'b0, rnd_data());
    checks++;
    if (o_rv !== 1'b0 || o_rid !== '0 || o_rd !== '0 || o_inf !== '0 || o_idle !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: rv=%b id=%0d rd=%h inf=%0d idle=%b, want 0 0 0 0 1",
               o_rv, o_rid, o_rd, o_inf, o_idle);
    end
  endtask

  task automatic test_single();
    logic [N*DW-1:0] d;
    step(4'b0000, 1'b0, 1'b1, rnd_data());
    for (int k = 0; k < 12; k++) begin
      d = rnd_data();
      d[DW-1:0] = 32'h1234_5678;
      step((k == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, d);
      checks++;
      if (obs !== ex_v) begin failures++; $display("FAIL single_model k=%0d: got %h want %h", k, obs, ex_v); end
      if (k == 0) begin
        checks++;
        if (o_gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b want 0001", o_gnt); end
      end
      if (k == 7) begin
        checks++;
        if (o_rv !== 1'b1 || o_rid !== 2'd0 || o_rd !== 32'h1234_5678) begin
          failures++; $display("FAIL single_rsp: rv=%b id=%0d rd=%h want 1 0 12345678", o_rv, o_rid, o_rd);
        end
      end
      if (k >= 1 && k <= 7) begin
        checks++;
        if (o_inf !== 3'd1) begin failures++; $display("FAIL single_inflight k=%0d: got %0d want 1", k, o_inf); end
      end
      if (k == 8) begin
        checks++;
        if (o_inf !== 3'd0 || o_idle !== 1'b1) begin
          failures++; $display("FAIL single_idle: inf=%0d idle=%b want 0 1", o_inf, o_idle);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int peak = 0;
    step(4'b0000, 1'b0, 1'b1, rnd_data());
    for (int k = 0; k < 18; k++) begin
      step((k < 8) ? 4'b1111 : 4'b0000, 1'b0, 1'b0, rnd_data());
      checks++;
      if (obs !== ex_v) begin failures++; $display("FAIL rr_model k=%0d: got %h want %h", k, obs, ex_v); end
      if (int'(o_inf) > peak) peak = int'(o_inf);
      if (k < 8) begin
        checks++;
        if (o_gnt !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_gnt k=%0d: got %b want id %0d", k, o_gnt, k % 4); end
      end
      if (k >= 7 && k <= 14) begin
        checks++;
        if (o_rv !== 1'b1 || int'(o_rid) != (k - 7) % 4) begin
          failures++; $display("FAIL rr_rsp k=%0d: rv=%b id=%0d want 1 %0d", k, o_rv, o_rid, (k - 7) % 4);
        end
      end
    end
    checks++;
    if (peak != 7) begin failures++; $display("FAIL rr_peak: got %0d want 7", peak); end
  endtask

  task automatic test_skip();
    logic [N-1:0] want [4];
    want = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    step(4'b0000, 1'b0, 1'b1, rnd_data());
    for (int k = 0; k < 4; k++) begin
      step(4'b1010, 1'b0, 1'b0, rnd_data());
      checks++;
      if (o_gnt !== want[k]) begin failures++; $display("FAIL skip_gnt k=%0d: got %b want %b", k, o_gnt, want[k]); end
    end
    step(4'b1111, 1'b0, 1'b0, rnd_data());
    checks++;
    if (o_gnt !== 4'b0001) begin failures++; $display("FAIL skip_ptr: got %b want 0001", o_gnt); end
    for (int k = 0; k < 10; k++) begin
      step(4'b0000, 1'b0, 1'b0, rnd_data());
      checks++;
      if (obs !== ex_v) begin failures++; $display("FAIL skip_model k=%0d: got %h want %h", k, obs, ex_v); end
    end
  endtask

  task automatic test_hold();
    step(4'b0000, 1'b0, 1'b1, rnd_data());
    for (int k = 0; k < 26; k++) begin
      step((k < 16) ? 4'b0011 : 4'b0000, (k >= 3 && k <= 5), 1'b0, rnd_data());
      checks++;
      if (obs !== ex_v) begin failures++; $display("FAIL hold_model k=%0d: got %h want %h", k, obs, ex_v); end
      if (k >= 3 && k <= 5) begin
        checks++;
        if (o_gnt !== 4'b0000) begin failures++; $display("FAIL hold_gnt k=%0d: got %b want 0000", k, o_gnt); end
      end
      if (k >= 7 && k <= 22) begin
        checks++;
        if (o_rv !== !(k >= 10 && k <= 12)) begin
          failures++; $display("FAIL hold_rsp k=%0d: got %b want %b", k, o_rv, !(k >= 10 && k <= 12));
        end
      end
      if (k == 22 || k == 23) begin
        checks++;
        if (o_idle !== (k == 23)) begin failures++; $display("FAIL hold_idle k=%0d: got %b want %b", k, o_idle, (k == 23)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(4'b0000, 1'b0, 1'b1, rnd_data());
    for (int k = 0; k < 4; k++) step(4'b1111, 1'b0, 1'b0, rnd_data());
    step(4'b1111, 1'b0, 1'b1, rnd_data());
    for (int k = 5; k < 21; k++) begin
      step(4'b0000, 1'b0, 1'b0, rnd_data());
      checks++;
      if (o_rv !== 1'b0 || o_rd !== '0 || o_inf !== '0) begin
        failures++; $display("FAIL rstmid_quiet k=%0d: rv=%b rd=%h inf=%0d want 0 0 0", k, o_rv, o_rd, o_inf);
      end
    end
    step(4'b1111, 1'b0, 1'b0, rnd_data());
    checks++;
    if (o_gnt !== 4'b0001) begin failures++; $display("FAIL rstmid_ptr: got %b want 0001", o_gnt); end
    for (int k = 0; k < 9; k++) step(4'b0000, 1'b0, 1'b0, rnd_data());
  endtask

  task automatic test_idle();
    for (int k = 0; k < 20; k++) begin
      step(4'b0000, 1'b0, 1'b0, rnd_data());
      checks++;
      if (o_pe !== 1'b0 || o_rv !== 1'b0 || o_rd !== '0 || o_idle !== 1'b1) begin
        failures++; $display("FAIL idle k=%0d: pe=%b rv=%b rd=%h idle=%b want 0 0 0 1", k, o_pe, o_rv, o_rd, o_idle);
      end
    end
  endtask

  task automatic test_random();
    step(4'b0000, 1'b0, 1'b1, rnd_data());
    for (int k = 0; k < 300; k++) begin
      step(4'($urandom), ($urandom % 5 == 0), ($urandom % 50 == 0), rnd_data());
      checks++;
      if (obs !== ex_v) begin failures++; $display("FAIL random_model k=%0d: got %h want %h", k, obs, ex_v); end
    end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; req = '0; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_skip();
    test_hold();
    test_reset_mid();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
